pc_update_ctrl: RTL and testbench

Sequential controller on the PC-write side of the datapath. It generates PCSource and PCWrite for the PC source multiplexer and owns the EPC register. It resolves same-cycle PC change requests: sequential step, jump, branch and return-from-exception. For exceptions it runs a multi-cycle sequence: save EPC, read the handler vector from memory, then load the vector into PC through the memData path.

---
 rtl/pc_update_ctrl.sv | 127 ++++++++++++
 tb/tb_pc_update_ctrl.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/pc_update_ctrl.sv
// PC-write controller: resolves same-cycle PC update requests, owns EPC, and
// sequences exception entry (save EPC, fetch vector, load vector into PC).
module pc_update_ctrl #(
  parameter int unsigned VEC_BASE = 253,
  parameter int unsigned MEM_LAT  = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        step_req,
  input  logic        jump_req,
  input  logic        branch_req,
  input  logic        zero,
  input  logic        rte_req,
  input  logic        exc_valid,
  input  logic [1:0]  exc_code,
  input  logic [31:0] pc_in,
  output logic [2:0]  PCSource,
  output logic        PCWrite,
  output logic [31:0] epc_out,
  output logic [31:0] mem_addr,
  output logic        mem_read,
  output logic        busy,
  output logic        exc_lost
);

  localparam logic [1:0] IDLE     = 2'd0;
  localparam logic [1:0] EXC_READ = 2'd1;
  localparam logic [1:0] EXC_WAIT = 2'd2;
  localparam logic [1:0] EXC_LOAD = 2'd3;

  localparam logic [2:0] SRC_JUMP   = 3'b000;
  localparam logic [2:0] SRC_RESULT = 3'b001;
  localparam logic [2:0] SRC_ALU    = 3'b010;
  localparam logic [2:0] SRC_MEM    = 3'b011;
  localparam logic [2:0] SRC_EPC    = 3'b100;

  localparam int unsigned CntW = (MEM_LAT < 2) ? 1 : $clog2(MEM_LAT + 1);
  localparam logic [CntW-1:0] LatInit = CntW'(MEM_LAT);
  localparam logic [31:0]     VecBase = 32'(VEC_BASE);

  logic [1:0]      state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [31:0]     epc_q, epc_d;
  logic [31:0]     addr_q, addr_d;
  logic            lost_q, lost_d;
  logic [1:0]      code_eff;

  // Unused code 2'b11 shares the invalid-opcode vector.
  assign code_eff = (exc_code == 2'b11) ? 2'b00 : exc_code;

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    epc_d    = epc_q;
    addr_d   = addr_q;
    lost_d   = lost_q;
    PCSource = SRC_RESULT;
    PCWrite  = 1'b0;
    mem_read = 1'b0;

    case (state_q)
      IDLE: begin
        if (exc_valid) begin
          epc_d   = pc_in - 32'd4;
          addr_d  = VecBase + {30'd0, code_eff};
          state_d = EXC_READ;
        end else if (rte_req) begin
          PCSource = SRC_EPC;
          PCWrite  = 1'b1;
        end else if (jump_req) begin
          PCSource = SRC_JUMP;
          PCWrite  = 1'b1;
        end else if (branch_req) begin
          PCSource = SRC_ALU;
          PCWrite  = zero;
        end else if (step_req) begin
          PCSource = SRC_RESULT;
          PCWrite  = 1'b1;
        end
      end
      EXC_READ: begin
        mem_read = 1'b1;
        cnt_d    = LatInit;
        state_d  = EXC_WAIT;
      end
      EXC_WAIT: begin
        cnt_d = cnt_q - CntW'(1);
        if (cnt_q == CntW'(1)) begin
          state_d = EXC_LOAD;
        end
      end
      EXC_LOAD: begin
        PCSource = SRC_MEM;
        PCWrite  = 1'b1;
        state_d  = IDLE;
      end
      default: state_d = IDLE;
    endcase

    // A second exception cannot be serviced mid-sequence; flag it and drop it.
    if ((state_q != IDLE) && exc_valid) begin
      lost_d = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      epc_q   <= '0;
      addr_q  <= '0;
      lost_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      epc_q   <= epc_d;
      addr_q  <= addr_d;
      lost_q  <= lost_d;
    end
  end

  assign busy     = (state_q != IDLE);
  assign epc_out  = epc_q;
  assign mem_addr = addr_q;
  assign exc_lost = lost_q;

endmodule

// File: tb/tb_pc_update_ctrl.sv
// Randomized bench for pc_update_ctrl: two instances (MEM_LAT 1 and 3) share stimulus and are
// compared each cycle against a reference model based on cycles elapsed since exception entry.
module tb_pc_update_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic        step_req, jump_req, branch_req, zero, rte_req, exc_valid;
  logic [1:0]  exc_code;
  logic [31:0] pc_in;

  logic [2:0]  src_a, src_b;
  logic        pcw_a, pcw_b, mr_a, mr_b, busy_a, busy_b, lost_a, lost_b;
  logic [31:0] epc_a, epc_b, addr_a, addr_b;

  int n_checks = 0;
  int n_errors = 0;

  int unsigned lat    [2] = '{1, 3};
  int unsigned m_age  [2];
  logic [31:0] m_epc  [2];
  logic [31:0] m_addr [2];
  logic        m_lost [2];

  always #5 clk = ~clk;

  pc_update_ctrl #(.VEC_BASE(253), .MEM_LAT(1)) dut_a (
    .clk(clk), .reset(reset), .step_req(step_req), .jump_req(jump_req),
    .branch_req(branch_req), .zero(zero), .rte_req(rte_req), .exc_valid(exc_valid),
    .exc_code(exc_code), .pc_in(pc_in), .PCSource(src_a), .PCWrite(pcw_a),
    .epc_out(epc_a), .mem_addr(addr_a), .mem_read(mr_a), .busy(busy_a), .exc_lost(lost_a)
  );

  pc_update_ctrl #(.VEC_BASE(253), .MEM_LAT(3)) dut_b (
    .clk(clk), .reset(reset), .step_req(step_req), .jump_req(jump_req),
    .branch_req(branch_req), .zero(zero), .rte_req(rte_req), .exc_valid(exc_valid),
    .exc_code(exc_code), .pc_in(pc_in), .PCSource(src_b), .PCWrite(pcw_b),
    .epc_out(epc_b), .mem_addr(addr_b), .mem_read(mr_b), .busy(busy_b), .exc_lost(lost_b)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      m_age[i]  = 0;
      m_epc[i]  = 32'd0;
      m_addr[i] = 32'd0;
      m_lost[i] = 1'b0;
    end
  endtask

  // Advance the model by one clock edge using the inputs present at that edge.
  task automatic model_step();
    for (int i = 0; i < 2; i++) begin
      if (reset) begin
        m_age[i] = 0; m_epc[i] = 0; m_addr[i] = 0; m_lost[i] = 0;
      end else if (m_age[i] == 0) begin
        if (exc_valid) begin
          m_epc[i]  = pc_in - 32'd4;
          m_addr[i] = 32'd253 + ((exc_code == 2'd3) ? 32'd0 : 32'(exc_code));
          m_age[i]  = 1;
        end
      end else begin
        if (exc_valid) m_lost[i] = 1'b1;
        m_age[i] = (m_age[i] == lat[i] + 2) ? 0 : m_age[i] + 1;
      end
    end
  endtask

  task automatic check_outputs();
    for (int i = 0; i < 2; i++) begin
      logic [2:0]  e_src, g_src;
      logic        e_pcw, e_mr, e_busy, load;
      logic        g_pcw, g_mr, g_busy, g_lost;
      logic [31:0] g_epc, g_addr;
      string       p;
      p = $sformatf("L%0d", lat[i]);
      if (i == 0) begin
        g_src = src_a; g_pcw = pcw_a; g_mr = mr_a; g_busy = busy_a; g_lost = lost_a;
        g_epc = epc_a; g_addr = addr_a;
      end else begin
        g_src = src_b; g_pcw = pcw_b; g_mr = mr_b; g_busy = busy_b; g_lost = lost_b;
        g_epc = epc_b; g_addr = addr_b;
      end
      load = 1'b0;
      if (m_age[i] == 0) begin
        e_busy = 1'b0; e_mr = 1'b0;
        if (exc_valid)       begin e_src = 3'b001; e_pcw = 1'b0; end
        else if (rte_req)    begin e_src = 3'b100; e_pcw = 1'b1; end
        else if (jump_req)   begin e_src = 3'b000; e_pcw = 1'b1; end
        else if (branch_req) begin e_src = 3'b010; e_pcw = zero; end
        else if (step_req)   begin e_src = 3'b001; e_pcw = 1'b1; end
        else                 begin e_src = 3'b001; e_pcw = 1'b0; end
      end else begin
        e_busy = 1'b1;
        e_mr   = (m_age[i] == 1);
        load   = (m_age[i] == lat[i] + 2);
        e_pcw  = load;
        e_src  = 3'b011;
      end
      check_eq({p, " PCWrite"}, 32'(g_pcw), 32'(e_pcw));
      check_eq({p, " busy"}, 32'(g_busy), 32'(e_busy));
      check_eq({p, " mem_read"}, 32'(g_mr), 32'(e_mr));
      check_eq({p, " epc_out"}, g_epc, m_epc[i]);
      check_eq({p, " mem_addr"}, g_addr, m_addr[i]);
      check_eq({p, " exc_lost"}, 32'(g_lost), 32'(m_lost[i]));
      if (m_age[i] == 0 || load) check_eq({p, " PCSource"}, 32'(g_src), 32'(e_src));
    end
  endtask

  // Called at posedge+1 with inputs set; checks at negedge, updates model at next posedge.
  task automatic cycle();
    @(negedge clk);
    check_outputs();
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic set_req(input logic s, input logic j, input logic b, input logic z,
                         input logic r, input logic e, input logic [1:0] c,
                         input logic [31:0] pc);
    step_req = s; jump_req = j; branch_req = b; zero = z;
    rte_req = r; exc_valid = e; exc_code = c; pc_in = pc;
  endtask

  initial begin
    model_reset();
    reset = 1'b1;
    set_req(0, 0, 0, 0, 0, 0, 2'd0, 32'd0);
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;

    // Reset state and same-cycle requests
    cycle();
    set_req(1, 0, 0, 0, 0, 0, 2'd0, 32'h10); cycle();
    set_req(1, 1, 0, 0, 0, 0, 2'd0, 32'h10); cycle();
    set_req(0, 0, 1, 0, 0, 0, 2'd0, 32'h10); cycle();
    set_req(0, 0, 1, 1, 0, 0, 2'd0, 32'h10); cycle();

    // Exception entry, code 1, pc_in 0x40
    set_req(0, 0, 0, 0, 0, 1, 2'd1, 32'h40); cycle();
    set_req(0, 0, 0, 0, 0, 0, 2'd0, 32'h0);
    check_eq("t3 epc", epc_a, 32'h3C);
    check_eq("t3 addr", addr_a, 32'd254);
    check_eq("t3 mem_read", 32'(mr_a), 32'd1);
    repeat (6) cycle();

    // Exception beats rte; code 3 maps to vector 0; EPC wraps
    set_req(0, 0, 0, 0, 1, 1, 2'd3, 32'h0); cycle();
    set_req(0, 0, 0, 0, 0, 0, 2'd0, 32'h0);
    check_eq("t4 epc", epc_b, 32'hFFFF_FFFC);
    check_eq("t4 addr", addr_b, 32'd253);
    repeat (6) cycle();
    set_req(0, 0, 0, 0, 1, 0, 2'd0, 32'h0); cycle();

    // Exception and jump while busy
    set_req(0, 0, 0, 0, 0, 1, 2'd2, 32'h100); cycle();
    set_req(0, 0, 0, 0, 0, 0, 2'd0, 32'h0); cycle();
    set_req(0, 1, 0, 0, 0, 1, 2'd0, 32'h200); cycle();
    set_req(0, 1, 0, 0, 0, 0, 2'd0, 32'h200); cycle();
    set_req(0, 0, 0, 0, 0, 0, 2'd0, 32'h0);
    check_eq("t5 lost", 32'(lost_b), 32'd1);
    check_eq("t5 epc", epc_b, 32'hFC);
    repeat (4) cycle();

    // Async reset in the wait state
    set_req(0, 0, 0, 0, 0, 1, 2'd0, 32'h80); cycle();
    set_req(0, 0, 0, 0, 0, 0, 2'd0, 32'h0); cycle();
    reset = 1'b1;
    #1;
    check_eq("t6 busy", 32'(busy_b), 32'd0);
    check_eq("t6 mem_read", 32'(mr_b), 32'd0);
    check_eq("t6 epc", epc_b, 32'd0);
    check_eq("t6 lost", 32'(lost_b), 32'd0);
    model_reset();
    cycle();
    reset = 1'b0;
    repeat (6) cycle();

    // Random traffic
    for (int n = 0; n < 3000; n++) begin
      if ($urandom_range(99) == 0) begin
        set_req(0, 0, 0, 0, 0, 0, 2'd0, 32'h0);
        reset = 1'b1;
        #1;
        model_reset();
        cycle();
        reset = 1'b0;
      end else begin
        set_req($urandom_range(1) == 1, $urandom_range(4) == 0, $urandom_range(4) == 0,
                $urandom_range(1) == 1, $urandom_range(9) == 0, $urandom_range(11) == 0,
                2'($urandom_range(3)), $urandom());
        cycle();
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
